// File: rtl/sync_pkg.sv
// Shared definitions for the template-sync sequencer and its datapath:
// controller state encoding and the default geometry both sides agree on.
package sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_DIFF  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ctrl_state_e;

    localparam int DIFF_ITER_LIMIT_DEF = 17;
    localparam int LOG2_DIFF_DEPTH_DEF = 5;
    localparam int TIMEOUT_CYC_DEF     = 4096;

endpackage

// File: rtl/sync_min_tracker.sv
// Tags each diff-memory read with its scan index, then keeps the running
// unsigned minimum of the returned words; ties keep the earliest index.
module sync_min_tracker
    import sync_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W  = LOG2_DIFF_DEPTH_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                issue,
    input  logic [IDX_W-1:0]    issue_idx,
    input  logic [2*DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]    best_idx,
    output logic [2*DATA_W-1:0] best_val
);

    logic [RD_LAT-1:0]   vld_pipe_r;
    logic [IDX_W-1:0]    idx_pipe_r [RD_LAT];
    logic                have_min_r;
    logic [IDX_W-1:0]    best_idx_r;
    logic [2*DATA_W-1:0] best_val_r;
    logic                load_s;

    // Load decision for the word whose tag leaves the pipe this cycle
    always_comb begin
        load_s = 1'b0;
        if (vld_pipe_r[RD_LAT-1]) begin
            load_s = !have_min_r || (rd_data < best_val_r);
        end else begin
            load_s = 1'b0;
        end
    end

    // Tag pipe and running minimum; clr only re-arms the first-word load so the
    // previous result stays visible until the new scan returns data
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                idx_pipe_r[i] <= {IDX_W{1'b0}};
            end
            have_min_r <= 1'b0;
            best_idx_r <= {IDX_W{1'b0}};
            best_val_r <= {(2*DATA_W){1'b0}};
        end else begin
            vld_pipe_r[0] <= issue;
            idx_pipe_r[0] <= issue_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                idx_pipe_r[i] <= idx_pipe_r[i-1];
            end
            if (clr) begin
                have_min_r <= 1'b0;
            end else if (load_s) begin
                have_min_r <= 1'b1;
                best_idx_r <= idx_pipe_r[RD_LAT-1];
                best_val_r <= rd_data;
            end else begin
                have_min_r <= have_min_r;
            end
        end
    end

    assign best_idx = best_idx_r;
    assign best_val = best_val_r;

endmodule

// File: rtl/sync_tmp_ctrl.sv
// Template-sync sequencer: template capture, diff accumulation, diff-memory
// scan and report of the minimum-sum alignment offset, with a phase watchdog.
module sync_tmp_ctrl
    import sync_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int LOG2_DIFF_DEPTH = LOG2_DIFF_DEPTH_DEF,
    parameter int DIFF_ITER_LIMIT = DIFF_ITER_LIMIT_DEF,
    parameter int MEM_RD_LAT      = 1,
    parameter int TIMEOUT_CYC     = TIMEOUT_CYC_DEF,
    parameter int LOG2_TIMEOUT    = 13
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       ack,
    input  logic                       cfg_done,
    input  logic                       diff_done,
    input  logic [2*DATA_W-1:0]        diff_data_i,
    output logic                       cfg_w_en,
    output logic                       diff_r_en,
    output logic                       diff_r_mem_en,
    output logic                       busy,
    output logic                       result_valid,
    output logic [LOG2_DIFF_DEPTH-1:0] best_idx,
    output logic [2*DATA_W-1:0]        best_val,
    output logic                       err_timeout
);

    localparam logic [LOG2_TIMEOUT-1:0]    WD_LAST  = LOG2_TIMEOUT'(TIMEOUT_CYC - 1);
    localparam logic [LOG2_DIFF_DEPTH-1:0] RD_LAST  = LOG2_DIFF_DEPTH'(DIFF_ITER_LIMIT - 1);
    localparam logic [1:0]                 DRN_LAST = 2'(MEM_RD_LAT - 1);

    ctrl_state_e                state_r;
    ctrl_state_e                next_s;
    logic [LOG2_TIMEOUT-1:0]    wd_cnt_r;
    logic [LOG2_DIFF_DEPTH-1:0] rd_cnt_r;
    logic [1:0]                 drn_cnt_r;
    logic                       cfg_w_en_r;
    logic                       diff_r_en_r;
    logic                       diff_r_mem_en_r;
    logic                       busy_r;
    logic                       result_valid_r;
    logic                       err_timeout_r;
    logic                       entering_s;
    logic                       scan_clr_s;

    // Next-state selection; sticky done flags let a start skip finished phases
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_done && diff_done) begin
                        next_s = ST_SCAN;
                    end else if (cfg_done) begin
                        next_s = ST_DIFF;
                    end else begin
                        next_s = ST_CFG;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_CFG: begin
                if (cfg_done) begin
                    next_s = ST_DIFF;
                end else if (wd_cnt_r == WD_LAST) begin
                    next_s = ST_ERR;
                end else begin
                    next_s = ST_CFG;
                end
            end
            ST_DIFF: begin
                if (diff_done) begin
                    next_s = ST_SCAN;
                end else if (wd_cnt_r == WD_LAST) begin
                    next_s = ST_ERR;
                end else begin
                    next_s = ST_DIFF;
                end
            end
            ST_SCAN: begin
                if (rd_cnt_r == RD_LAST) begin
                    next_s = ST_DRAIN;
                end else begin
                    next_s = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (drn_cnt_r == DRN_LAST) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_DONE;
                end
            end
            ST_ERR: begin
                if (ack) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_ERR;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    assign entering_s = (next_s != state_r);
    assign scan_clr_s = entering_s && (next_s == ST_SCAN);

    // State, watchdog, read/drain counters and outputs registered from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            wd_cnt_r        <= {LOG2_TIMEOUT{1'b0}};
            rd_cnt_r        <= {LOG2_DIFF_DEPTH{1'b0}};
            drn_cnt_r       <= 2'd0;
            cfg_w_en_r      <= 1'b0;
            diff_r_en_r     <= 1'b0;
            diff_r_mem_en_r <= 1'b0;
            busy_r          <= 1'b0;
            result_valid_r  <= 1'b0;
            err_timeout_r   <= 1'b0;
        end else begin
            state_r <= next_s;

            if (entering_s) begin
                wd_cnt_r <= {LOG2_TIMEOUT{1'b0}};
            end else if ((state_r == ST_CFG) || (state_r == ST_DIFF)) begin
                wd_cnt_r <= wd_cnt_r + 1'b1;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end

            // rd_cnt doubles as the scan index attached to each issued read
            if (scan_clr_s) begin
                rd_cnt_r <= {LOG2_DIFF_DEPTH{1'b0}};
            end else if (state_r == ST_SCAN) begin
                rd_cnt_r <= rd_cnt_r + 1'b1;
            end else begin
                rd_cnt_r <= rd_cnt_r;
            end

            if (entering_s) begin
                drn_cnt_r <= 2'd0;
            end else if (state_r == ST_DRAIN) begin
                drn_cnt_r <= drn_cnt_r + 2'd1;
            end else begin
                drn_cnt_r <= drn_cnt_r;
            end

            cfg_w_en_r      <= (next_s == ST_CFG);
            diff_r_en_r     <= (next_s == ST_DIFF);
            diff_r_mem_en_r <= (next_s == ST_SCAN);
            busy_r          <= (next_s != ST_IDLE);
            result_valid_r  <= (next_s == ST_DONE);
            err_timeout_r   <= (next_s == ST_ERR);
        end
    end

    sync_min_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (LOG2_DIFF_DEPTH),
        .RD_LAT (MEM_RD_LAT)
    ) u_min_tracker (
        .clk       (clk),
        .reset     (reset),
        .clr       (scan_clr_s),
        .issue     (diff_r_mem_en_r),
        .issue_idx (rd_cnt_r),
        .rd_data   (diff_data_i),
        .best_idx  (best_idx),
        .best_val  (best_val)
    );

    assign cfg_w_en      = cfg_w_en_r;
    assign diff_r_en     = diff_r_en_r;
    assign diff_r_mem_en = diff_r_mem_en_r;
    assign busy          = busy_r;
    assign result_valid  = result_valid_r;
    assign err_timeout   = err_timeout_r;

endmodule

// File: tb/tb_sync_tmp_ctrl.sv
// Directed bench for sync_tmp_ctrl: two instances (read latency 1 and 2) share
// the control inputs, each fed by its own model of the auto-incrementing diff memory.
module tb_sync_tmp_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ack;
    logic        cfg_done;
    logic        diff_done;
    logic [31:0] data1, data2, d2a;
    logic        cfg1, diff1, mem1, busy1, rv1, err1;
    logic        cfg2, diff2, mem2, busy2, rv2, err2;
    logic [4:0]  bidx1, bidx2;
    logic [31:0] bval1, bval2;
    logic [4:0]  addr1, addr2;
    logic [31:0] mem [32];

    int n_cmp = 0;
    int n_err = 0;

    sync_tmp_ctrl #(.MEM_RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .cfg_done(cfg_done), .diff_done(diff_done), .diff_data_i(data1),
        .cfg_w_en(cfg1), .diff_r_en(diff1), .diff_r_mem_en(mem1), .busy(busy1),
        .result_valid(rv1), .best_idx(bidx1), .best_val(bval1), .err_timeout(err1)
    );

    sync_tmp_ctrl #(.MEM_RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .cfg_done(cfg_done), .diff_done(diff_done), .diff_data_i(data2),
        .cfg_w_en(cfg2), .diff_r_en(diff2), .diff_r_mem_en(mem2), .busy(busy2),
        .result_valid(rv2), .best_idx(bidx2), .best_val(bval2), .err_timeout(err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Diff memory models: address auto-increments per read, cleared by reset
    always @(posedge clk) begin
        if (reset) begin
            addr1 <= 5'd0;
            addr2 <= 5'd0;
        end else begin
            if (mem1) begin
                addr1 <= addr1 + 5'd1;
                data1 <= mem[addr1];
            end
            if (mem2) begin
                addr2 <= addr2 + 5'd1;
                d2a   <= mem[addr2];
            end
            data2 <= d2a;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        cfg_done  = 1'b0;
        diff_done = 1'b0;
        start     = 1'b0;
        ack       = 1'b0;
        reset     = 1'b1;
        tick(2);
        reset     = 1'b0;
        tick(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Called at the first SCAN cycle; pulses a stray ack mid-scan, then checks the result
    task automatic scan_and_check(input string tag, input logic [4:0] exp_idx, input logic [31:0] exp_val);
        int n1 = 0;
        int n2 = 0;
        int lat1 = -1;
        int lat2 = -1;
        for (int c = 0; c < 100; c++) begin
            if (mem1) n1++;
            if (mem2) n2++;
            if (rv1 && lat1 < 0) lat1 = c;
            if (rv2 && lat2 < 0) lat2 = c;
            if (lat1 >= 0 && lat2 >= 0) break;
            ack = (c == 3);
            tick(1);
        end
        ack = 1'b0;
        check_val({tag, "_reads1"}, n1, 17);
        check_val({tag, "_reads2"}, n2, 17);
        check_val({tag, "_lat1"}, lat1, 18);
        check_val({tag, "_lat2"}, lat2, 19);
        check_val({tag, "_idx1"}, bidx1, exp_idx);
        check_val({tag, "_val1"}, bval1, exp_val);
        check_val({tag, "_idx2"}, bidx2, exp_idx);
        check_val({tag, "_val2"}, bval2, exp_val);
        tick(3);
        check_val({tag, "_hold_valid"}, {rv1, rv2, busy1}, 3'b111);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_val({tag, "_ack_idle"}, {busy1, rv1, busy2, rv2}, 4'b0000);
        check_val({tag, "_idx_kept"}, bidx1, exp_idx);
    endtask

    task automatic load_unique_min();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_1000 + 32'(i) * 32'h100;
        mem[9] = 32'h0000_0010;
    endtask

    initial begin
        int ncfg;
        int nrd;
        logic got_err;
        reset = 1'b1; start = 1'b0; ack = 1'b0; cfg_done = 1'b0; diff_done = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_0000;
        tick(3);
        check_val("reset_state1", {busy1, cfg1, diff1, mem1, rv1, err1, bidx1, bval1}, 64'd0);
        check_val("reset_state2", {busy2, cfg2, diff2, mem2, rv2, err2, bidx2, bval2}, 64'd0);

        // Normal run with a unique minimum at index 9
        load_unique_min();
        reset = 1'b0;
        tick(1);
        pulse_start();
        check_val("cfg_entry", {busy1, cfg1, diff1, mem1}, 4'b1100);
        tick(49);
        cfg_done = 1'b1;
        tick(1);
        check_val("diff_entry", {cfg1, diff1, mem1}, 3'b010);
        pulse_start();
        check_val("stray_start_diff", {busy1, cfg1, diff1, mem1}, 4'b1010);
        tick(898);
        diff_done = 1'b1;
        tick(1);
        check_val("scan_entry", {cfg1, diff1, mem1, cfg2, diff2, mem2}, 6'b001001);
        scan_and_check("normal", 5'd9, 32'h10);

        // Sticky flags skip CFG/DIFF; tie at 3 and 12 keeps the lower index
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0100 + 32'(i);
        mem[3]  = 32'h20;
        mem[12] = 32'h20;
        cfg_done  = 1'b1;
        diff_done = 1'b1;
        pulse_start();
        check_val("sticky_scan_now", {cfg1, diff1, mem1, busy1}, 4'b0011);
        scan_and_check("tie", 5'd3, 32'h20);

        // Huge first word still loads; minimum at the last index
        do_reset();
        mem[0] = 32'hFFFF_FFFF;
        for (int i = 1; i < 32; i++) mem[i] = 32'h0000_5000 + 32'(i);
        mem[16] = 32'h7;
        cfg_done  = 1'b1;
        diff_done = 1'b1;
        pulse_start();
        scan_and_check("last_idx", 5'd16, 32'h7);

        // Watchdog: cfg_done never rises
        do_reset();
        pulse_start();
        ncfg = 0;
        got_err = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (err1) begin
                got_err = 1'b1;
                break;
            end
            if (cfg1) ncfg++;
            tick(1);
        end
        check_val("timeout_err", got_err, 1'b1);
        check_val("timeout_cycles", ncfg, 4096);
        check_val("timeout_outputs", {cfg1, diff1, mem1, err2, cfg2}, 5'b00010);
        pulse_start();
        check_val("stray_start_err", {err1, busy1}, 2'b11);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_val("timeout_ack", {err1, busy1, err2}, 3'b000);

        // Reset after eight reads, then a full sequence
        do_reset();
        load_unique_min();
        cfg_done  = 1'b1;
        diff_done = 1'b1;
        pulse_start();
        nrd = 0;
        for (int c = 0; c < 40; c++) begin
            if (mem1) nrd++;
            if (nrd == 8) break;
            tick(1);
        end
        check_val("pre_reset_reads", nrd, 8);
        reset = 1'b1;
        cfg_done  = 1'b0;
        diff_done = 1'b0;
        tick(1);
        reset = 1'b0;
        check_val("midscan_reset1", {busy1, cfg1, diff1, mem1, rv1, err1, bidx1, bval1}, 64'd0);
        check_val("midscan_reset2", {busy2, cfg2, diff2, mem2, rv2, err2, bidx2, bval2}, 64'd0);
        tick(1);
        pulse_start();
        check_val("rerun_cfg", {cfg1, diff1}, 2'b10);
        tick(4);
        cfg_done = 1'b1;
        tick(1);
        check_val("rerun_diff", {cfg1, diff1}, 2'b01);
        tick(5);
        diff_done = 1'b1;
        tick(1);
        check_val("rerun_scan", {diff1, mem1}, 2'b01);
        scan_and_check("rerun", 5'd9, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_tmp_ctrl.md
Name: sync_tmp_ctrl

Overview:
Sequencer for the template-sync datapath (template capture, then windowed absolute-difference accumulation into the diff memory). It runs four phases in order:
- drives the template write enable until the datapath reports config done;
- drives the diff read enable until all difference sums are written;
- reads the diff memory back in address order;
- reports the minimum sum and its index as the best alignment offset to downstream fiducial logic.

Parameters:
- DATA_W, 16, sample width; diff words are 2*DATA_W.
- LOG2_DIFF_DEPTH, 5, diff memory address width.
- DIFF_ITER_LIMIT, 17, number of valid diff entries to scan (1..2^LOG2_DIFF_DEPTH).
- MEM_RD_LAT, 1, diff memory read latency in cycles (1 or 2).
- TIMEOUT_CYC, 4096, max cycles allowed in CFG or DIFF before error.
- LOG2_TIMEOUT, 13, watchdog counter width (must hold TIMEOUT_CYC).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a sequence from IDLE, ignored elsewhere.
- ack  in  1  consumer acknowledges result/error; DONE/ERR -> IDLE.
- cfg_done  in  1  datapath template-capture complete (sticky).
- diff_done  in  1  datapath all diff sums written (sticky).
- diff_data_i  in  2*DATA_W  diff memory read data.
- cfg_w_en  out  1  template write enable to datapath.
- diff_r_en  out  1  diff computation enable to datapath.
- diff_r_mem_en  out  1  diff memory read enable (address auto-increments in datapath).
- busy  out  1  high in any state except IDLE.
- result_valid  out  1  high in DONE.
- best_idx  out  LOG2_DIFF_DEPTH  index of minimum diff sum.
- best_val  out  2*DATA_W  minimum diff sum (unsigned).
- err_timeout  out  1  high in ERR.

Behaviour:
- Reset (synchronous, active-high): state IDLE, all outputs 0, best_val 0, best_idx 0, counters 0. Reset dominates every other input in the same cycle.
- States: IDLE, CFG, DIFF, SCAN, DRAIN, DONE, ERR.
- IDLE: start=1 -> CFG next cycle. If cfg_done is already 1, go directly to DIFF; if diff_done is also 1, go to SCAN.
- CFG: cfg_w_en=1. Leave the cycle after cfg_done is sampled 1 -> DIFF, with cfg_w_en low that same cycle. Watchdog reaching TIMEOUT_CYC -> ERR.
- DIFF: diff_r_en=1 until diff_done sampled 1 -> SCAN, with diff_r_en low that cycle. Watchdog reaching TIMEOUT_CYC -> ERR.
- Watchdog: clears on every state entry, counts each cycle in CFG/DIFF.
- SCAN:
  - diff_r_mem_en=1 for exactly DIFF_ITER_LIMIT consecutive cycles, counted by issue counter rd_cnt.
  - Then -> DRAIN for MEM_RD_LAT cycles.
- Compare path:
  - A valid shift register of depth MEM_RD_LAT tags each issued read with its index.
  - When the tag emerges, diff_data_i is compared unsigned against the running minimum.
  - The first returned word always loads. Afterwards load only on strictly less, so ties keep the lowest index.
- DRAIN -> DONE once the last tag is consumed. result_valid=1; best_idx/best_val stable.
- DONE: hold until ack=1 -> IDLE. best_idx/best_val hold until the next SCAN's first load.
- ERR: err_timeout=1, all enables 0; ack=1 -> IDLE.
- start outside IDLE is ignored. ack outside DONE/ERR is ignored.
- Enables are registered outputs, mutually exclusive, never asserted in IDLE/DONE/ERR.
- Datapath counters are cleared only by global reset; a second sequence without reset skips CFG/DIFF via the sticky flags. Its SCAN reads continue from the datapath's wrapped read address; this is accepted behaviour.

Decomposition:
- Shared package sync_pkg: state encoding constants (IDLE..ERR, 3-bit), and defaults DIFF_ITER_LIMIT, LOG2_DIFF_DEPTH, TIMEOUT_CYC shared with the datapath instance.
- One sub-module: sync_min_tracker. Holds the read-latency tag pipe plus running minimum/index with a clear input. The controller FSM, watchdog and rd_cnt stay in the top.

Test Plan:
- Normal run, MEM_RD_LAT=1: pulse start; cfg_done 50 cycles later; diff_done 900 cycles later; diff memory returns 17 words, with index 9=0x00000010 the unique minimum -> exactly 17 diff_r_mem_en cycles, result_valid, best_idx=9, best_val=0x10. ack -> IDLE, busy=0.
- Tie: words 3 and 12 both 0x20 (minimum) -> best_idx=3.
- Timeout: start; cfg_done never rises -> err_timeout=1 at 4096 cycles in CFG, cfg_w_en=0. ack -> IDLE.
- Sticky flags: cfg_done=diff_done=1 at start -> CFG and DIFF skipped, SCAN entered in the cycle after IDLE. With MEM_RD_LAT=2, result appears DIFF_ITER_LIMIT+2 cycles after SCAN entry.
- Reset mid-SCAN (after 8 reads): reset=1 one cycle -> next cycle all outputs 0, state IDLE. A following start runs a full sequence.
- Stray controls: start asserted in DIFF and ack asserted in SCAN -> no state change, enables unaffected.
